// File: rtl/npc_predict_if.sv
// npc_predict_if -- fetch/resolve bus of the next-PC predictor.
//   Fetch side  : stall in, pc_o / pred_taken_o / pred_target_o out.
//   Resolve side: res_* describe one control-flow instruction leaving EX;
//                 flush_o and mispred_cnt_o report mispredictions.
//   master = pipeline (drives stall and res_*), slave = predictor.
interface npc_predict_if #(
   parameter int ADDR_W = 32
);
   logic              stall;
   logic [ADDR_W-1:0] pc_o;
   logic              pred_taken_o;
   logic [ADDR_W-1:0] pred_target_o;
   logic              res_valid;
   logic [ADDR_W-1:0] res_pc;
   logic              res_cond;
   logic              res_taken;
   logic [ADDR_W-1:0] res_target;
   logic              res_pred_taken;
   logic [ADDR_W-1:0] res_pred_target;
   logic              flush_o;
   logic [31:0]       mispred_cnt_o;

   modport master (
      output stall, res_valid, res_pc, res_cond, res_taken, res_target,
             res_pred_taken, res_pred_target,
      input  pc_o, pred_taken_o, pred_target_o, flush_o, mispred_cnt_o
   );

   modport slave (
      input  stall, res_valid, res_pc, res_cond, res_taken, res_target,
             res_pred_taken, res_pred_target,
      output pc_o, pred_taken_o, pred_target_o, flush_o, mispred_cnt_o
   );
endinterface

// File: rtl/npc_predict.sv
// npc_predict -- fetch PC register with a direct-mapped branch target buffer
// and 2-bit saturating direction counters.
//   clk : single clock, rising edge
//   rst : synchronous active-high reset
//   bus : npc_predict_if.slave (stall, res_* in; pc_o, pred_*, flush_o,
//         mispred_cnt_o out)
// Lookup is combinational on the registered fetch PC; training and
// redirection come from the resolve port. A same-cycle update of the looked-up
// index is seen only from the next cycle on (lookup reads the registers).
module npc_predict #(
   parameter int                ADDR_W      = 32,
   parameter int                BTB_ENTRIES = 16,
   parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(32'h0000_3000)
) (
   input logic          clk,
   input logic          rst,
   npc_predict_if.slave bus
);
   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;

   logic              valid_r  [BTB_ENTRIES];
   logic [TAG_W-1:0]  tag_r    [BTB_ENTRIES];
   logic [ADDR_W-1:0] target_r [BTB_ENTRIES];
   logic              uncond_r [BTB_ENTRIES];
   logic [1:0]        ctr_r    [BTB_ENTRIES];
   logic [ADDR_W-1:0] pc_r;
   logic [31:0]       mispred_cnt_r;

   logic [IDX_W-1:0]  idx_s;
   logic [TAG_W-1:0]  tag_s;
   logic              hit_s;
   logic              pred_taken_s;
   logic [ADDR_W-1:0] pred_target_s;

   logic [IDX_W-1:0]  res_idx_s;
   logic [TAG_W-1:0]  res_tag_s;
   logic              res_hit_s;
   logic [1:0]        res_ctr_s;
   logic [1:0]        ctr_next_s;
   logic              flush_s;
   logic [ADDR_W-1:0] correct_pc_s;
   logic              entry_we_s;
   logic              ctr_we_s;

   // Fetch-side lookup: prediction for the current fetch PC.
   always_comb begin
      idx_s         = pc_r[IDX_W+1:2];
      tag_s         = pc_r[ADDR_W-1:IDX_W+2];
      hit_s         = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
      pred_taken_s  = hit_s && (uncond_r[idx_s] || ctr_r[idx_s][1]);
      if (pred_taken_s) begin
         pred_target_s = target_r[idx_s];
      end else begin
         pred_target_s = pc_r + ADDR_W'(4);
      end
   end

   // Resolve side: mispredict detection, correct next PC and write enables.
   always_comb begin
      res_idx_s = bus.res_pc[IDX_W+1:2];
      res_tag_s = bus.res_pc[ADDR_W-1:IDX_W+2];
      res_hit_s = valid_r[res_idx_s] && (tag_r[res_idx_s] == res_tag_s);
      res_ctr_s = ctr_r[res_idx_s];
      flush_s   = bus.res_valid &&
                  ((bus.res_taken != bus.res_pred_taken) ||
                   (bus.res_taken && (bus.res_target != bus.res_pred_target)));
      if (bus.res_taken) begin
         correct_pc_s = bus.res_target;
      end else begin
         correct_pc_s = bus.res_pc + ADDR_W'(4);
      end
      // Taken allocates or refreshes the entry; not-taken only trains a hit.
      entry_we_s = bus.res_valid && bus.res_taken;
      ctr_we_s   = bus.res_valid && (bus.res_taken || res_hit_s);
   end

   // Next counter value for the resolved entry.
   always_comb begin
      ctr_next_s = res_ctr_s;
      if (bus.res_taken) begin
         if (!bus.res_cond) begin
            ctr_next_s = 2'b11;                  // jumps always predict taken
         end else if (res_hit_s) begin
            if (res_ctr_s != 2'b11) begin
               ctr_next_s = res_ctr_s + 2'b01;
            end else begin
               ctr_next_s = 2'b11;
            end
         end else begin
            ctr_next_s = 2'b10;                  // fresh allocation: weakly taken
         end
      end else begin
         if (res_ctr_s != 2'b00) begin
            ctr_next_s = res_ctr_s - 2'b01;
         end else begin
            ctr_next_s = 2'b00;
         end
      end
   end

   // Fetch PC: reset, then redirect (wins over stall), then hold, then predict.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r <= RESET_PC;
      end else if (flush_s) begin
         pc_r <= correct_pc_s;
      end else if (bus.stall) begin
         pc_r <= pc_r;
      end else begin
         pc_r <= pred_target_s;
      end
   end

   // Mispredict counter, wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         mispred_cnt_r <= 32'd0;
      end else if (flush_s) begin
         mispred_cnt_r <= mispred_cnt_r + 32'd1;
      end else begin
         mispred_cnt_r <= mispred_cnt_r;
      end
   end

   // BTB training; independent of stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            valid_r[i]  <= 1'b0;
            tag_r[i]    <= '0;
            target_r[i] <= '0;
            uncond_r[i] <= 1'b0;
            ctr_r[i]    <= 2'b01;
         end
      end else begin
         if (entry_we_s) begin
            valid_r[res_idx_s]  <= 1'b1;
            tag_r[res_idx_s]    <= res_tag_s;
            target_r[res_idx_s] <= bus.res_target;
            uncond_r[res_idx_s] <= ~bus.res_cond;
         end
         if (ctr_we_s) begin
            ctr_r[res_idx_s] <= ctr_next_s;
         end
      end
   end

   assign bus.pc_o          = pc_r;
   assign bus.pred_taken_o  = pred_taken_s;
   assign bus.pred_target_o = pred_target_s;
   assign bus.flush_o       = flush_s;
   assign bus.mispred_cnt_o = mispred_cnt_r;
endmodule

// File: tb/tb_npc_predict.sv
// tb_npc_predict -- directed vector table for the documented scenarios, then
// randomized traffic checked against a behavioural BTB/PC model.
module tb_npc_predict;
   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam int          NENT   = 16;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_mis;

   npc_predict_if #(.ADDR_W(32)) bus ();

   npc_predict #(.ADDR_W(32), .BTB_ENTRIES(NENT), .RESET_PC(RST_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst, stall, rv;
      logic [31:0] rpc;
      logic        rcond, rtaken;
      logic [31:0] rtgt;
      logic        rpt;
      logic [31:0] rptgt;
      logic [31:0] e_pc;
      logic        e_pt;
      logic [31:0] e_ptgt;
      logic        e_fl;
      logic [31:0] e_cnt;
   } vec_t;

   function automatic vec_t mk(logic r, logic s, logic v, logic [31:0] pc,
                               logic c, logic t, logic [31:0] tg, logic pt,
                               logic [31:0] ptg, logic [31:0] epc, logic ept,
                               logic [31:0] eptg, logic efl, logic [31:0] ecnt);
      vec_t x;
      x.rst = r; x.stall = s; x.rv = v; x.rpc = pc; x.rcond = c; x.rtaken = t;
      x.rtgt = tg; x.rpt = pt; x.rptgt = ptg; x.e_pc = epc; x.e_pt = ept;
      x.e_ptgt = eptg; x.e_fl = efl; x.e_cnt = ecnt;
      return x;
   endfunction

   // Behavioural model: a plain table indexed by word address mod NENT.
   logic [31:0] m_pc;
   logic [31:0] m_cnt;
   bit          m_valid [NENT];
   logic [31:0] m_tag   [NENT];
   logic [31:0] m_tgt   [NENT];
   bit          m_unc   [NENT];
   int          m_ctr   [NENT];

   function automatic int m_idx(logic [31:0] a);
      return int'((a / 32'd4) % NENT);
   endfunction

   function automatic bit m_hit(logic [31:0] a);
      return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == a / (32'd4 * NENT));
   endfunction

   function automatic bit m_pt(logic [31:0] a);
      return m_hit(a) && (m_unc[m_idx(a)] || m_ctr[m_idx(a)] >= 2);
   endfunction

   function automatic logic [31:0] m_ptgt(logic [31:0] a);
      return m_pt(a) ? m_tgt[m_idx(a)] : a + 32'd4;
   endfunction

   function automatic bit m_flush();
      return bus.res_valid && ((bus.res_taken != bus.res_pred_taken) ||
             (bus.res_taken && bus.res_target != bus.res_pred_target));
   endfunction

   task automatic m_clear();
      for (int i = 0; i < NENT; i++) begin
         m_valid[i] = 1'b0; m_tag[i] = 32'd0; m_tgt[i] = 32'd0;
         m_unc[i] = 1'b0; m_ctr[i] = 1;
      end
      m_pc  = RST_PC;
      m_cnt = 32'd0;
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(vec_t v);
      rst                 = v.rst;
      bus.stall           = v.stall;
      bus.res_valid       = v.rv;
      bus.res_pc          = v.rpc;
      bus.res_cond        = v.rcond;
      bus.res_taken       = v.rtaken;
      bus.res_target      = v.rtgt;
      bus.res_pred_taken  = v.rpt;
      bus.res_pred_target = v.rptgt;
      #2;
   endtask

   // Advance one clock, updating the model from the inputs currently applied.
   task automatic tick();
      logic [31:0] npc;
      bit          fl;
      int          ix;
      bit          hit;
      fl  = m_flush();
      npc = m_ptgt(m_pc);
      if (rst) begin
         m_clear();
      end else begin
         if (fl) npc = bus.res_taken ? bus.res_target : bus.res_pc + 32'd4;
         else if (bus.stall) npc = m_pc;
         if (fl) m_cnt = m_cnt + 32'd1;
         if (bus.res_valid) begin
            ix  = m_idx(bus.res_pc);
            hit = m_hit(bus.res_pc);
            if (bus.res_taken) begin
               if (!bus.res_cond) m_ctr[ix] = 3;
               else if (hit) m_ctr[ix] = (m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3;
               else m_ctr[ix] = 2;
               m_valid[ix] = 1'b1;
               m_tag[ix]   = bus.res_pc / (32'd4 * NENT);
               m_tgt[ix]   = bus.res_target;
               m_unc[ix]   = !bus.res_cond;
            end else if (hit) begin
               m_ctr[ix] = (m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0;
            end
         end
         m_pc = npc;
      end
      @(posedge clk);
      #1;
   endtask

   vec_t tbl [27];
   vec_t rv_v;

   initial begin
      n_vec = 0;
      n_mis = 0;
      //            rst s v rpc         c t rtgt        pt rptgt        pc          pt ptgt        fl cnt
      tbl[0]  = mk(0,0,0,32'h0,      0,0,32'h0,      0,32'h0,      32'h3000,0,32'h3004,0,32'd0);
      tbl[1]  = mk(0,0,0,32'h0,      0,0,32'h0,      0,32'h0,      32'h3004,0,32'h3008,0,32'd0);
      tbl[2]  = mk(0,0,0,32'h0,      0,0,32'h0,      0,32'h0,      32'h3008,0,32'h300C,0,32'd0);
      tbl[3]  = mk(0,0,0,32'h0,      0,0,32'h0,      0,32'h0,      32'h300C,0,32'h3010,0,32'd0);
      tbl[4]  = mk(0,0,1,32'h3008,   1,1,32'h3100,   0,32'h300C,   32'h3010,0,32'h3014,1,32'd0);
      tbl[5]  = mk(0,0,1,32'h3004,   1,0,32'h0,      1,32'h3100,   32'h3100,0,32'h3104,1,32'd1);
      tbl[6]  = mk(0,0,0,32'h0,      0,0,32'h0,      0,32'h0,      32'h3008,1,32'h3100,0,32'd2);
      tbl[7]  = mk(0,0,1,32'h3008,   1,0,32'h0,      0,32'h300C,   32'h3100,0,32'h3104,0,32'd2);
      tbl[8]  = mk(0,0,1,32'h3008,   1,0,32'h0,      0,32'h300C,   32'h3104,0,32'h3108,0,32'd2);
      tbl[9]  = mk(0,0,1,32'h3004,   1,1,32'h3008,   0,32'h3008,   32'h3108,0,32'h310C,1,32'd2);
      tbl[10] = mk(0,0,0,32'h0,      0,0,32'h0,      0,32'h0,      32'h3008,0,32'h300C,0,32'd3);
      tbl[11] = mk(0,0,1,32'h3010,   1,0,32'h0,      0,32'h3014,   32'h300C,0,32'h3010,0,32'd3);
      tbl[12] = mk(0,0,0,32'h0,      0,0,32'h0,      0,32'h0,      32'h3010,0,32'h3014,0,32'd3);
      tbl[13] = mk(0,1,1,32'h3010,   0,1,32'h3400,   0,32'h3014,   32'h3014,0,32'h3018,1,32'd3);
      tbl[14] = mk(0,1,0,32'h0,      0,0,32'h0,      0,32'h0,      32'h3400,0,32'h3404,0,32'd4);
      tbl[15] = mk(0,0,1,32'h300C,   1,1,32'h3010,   1,32'h3020,   32'h3400,0,32'h3404,1,32'd4);
      tbl[16] = mk(0,0,0,32'h0,      0,0,32'h0,      0,32'h0,      32'h3010,1,32'h3400,0,32'd5);
      tbl[17] = mk(0,0,1,32'h3048,   1,1,32'h3200,   0,32'h304C,   32'h3400,0,32'h3404,1,32'd5);
      tbl[18] = mk(0,0,1,32'h3004,   1,1,32'h3008,   0,32'h3008,   32'h3200,0,32'h3204,1,32'd6);
      tbl[19] = mk(0,0,0,32'h0,      0,0,32'h0,      0,32'h0,      32'h3008,0,32'h300C,0,32'd7);
      tbl[20] = mk(0,0,1,32'h300C,   1,0,32'h0,      1,32'h3010,   32'h300C,1,32'h3010,1,32'd7);
      tbl[21] = mk(1,0,1,32'h3000,   1,1,32'h3500,   0,32'h3004,   32'h3010,1,32'h3400,1,32'd8);
      tbl[22] = mk(0,0,0,32'h0,      0,0,32'h0,      0,32'h0,      32'h3000,0,32'h3004,0,32'd0);
      tbl[23] = mk(0,0,0,32'h0,      0,0,32'h0,      0,32'h0,      32'h3004,0,32'h3008,0,32'd0);
      tbl[24] = mk(0,0,0,32'h0,      0,0,32'h0,      0,32'h0,      32'h3008,0,32'h300C,0,32'd0);
      tbl[25] = mk(0,0,0,32'h0,      0,0,32'h0,      0,32'h0,      32'h300C,0,32'h3010,0,32'd0);
      tbl[26] = mk(0,0,0,32'h0,      0,0,32'h0,      0,32'h0,      32'h3010,0,32'h3014,0,32'd0);

      // Two reset cycles bring DUT and model to a known state.
      rv_v = mk(1,0,0,32'h0,0,0,32'h0,0,32'h0,32'h0,0,32'h0,0,32'd0);
      drive(rv_v);
      tick();
      tick();

      for (int i = 0; i < 27; i++) begin
         drive(tbl[i]);
         chk($sformatf("pc_o[%0d]", i),          bus.pc_o,                 tbl[i].e_pc);
         chk($sformatf("pred_taken_o[%0d]", i),  32'(bus.pred_taken_o),    32'(tbl[i].e_pt));
         chk($sformatf("pred_target_o[%0d]", i), bus.pred_target_o,        tbl[i].e_ptgt);
         chk($sformatf("flush_o[%0d]", i),       32'(bus.flush_o),         32'(tbl[i].e_fl));
         chk($sformatf("mispred_cnt_o[%0d]", i), bus.mispred_cnt_o,        tbl[i].e_cnt);
         tick();
      end

      // Randomized traffic over a small address window so entries hit and alias.
      for (int n = 0; n < 400; n++) begin
         rv_v.rst    = ($urandom_range(0, 99) < 2);
         rv_v.stall  = ($urandom_range(0, 99) < 20);
         rv_v.rv     = ($urandom_range(0, 99) < 60);
         rv_v.rpc    = 32'h3000 + 32'd4 * 32'($urandom_range(0, 31));
         rv_v.rcond  = ($urandom_range(0, 3) != 0);
         rv_v.rtaken = rv_v.rcond ? 1'($urandom_range(0, 1)) : 1'b1;
         rv_v.rtgt   = 32'h3000 + 32'd4 * 32'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 0) begin
            rv_v.rpt   = rv_v.rtaken;
            rv_v.rptgt = rv_v.rtaken ? rv_v.rtgt : rv_v.rpc + 32'd4;
         end else begin
            rv_v.rpt   = 1'($urandom_range(0, 1));
            rv_v.rptgt = 32'h3000 + 32'd4 * 32'($urandom_range(0, 63));
         end
         drive(rv_v);
         chk("rnd pc_o",          bus.pc_o,              m_pc);
         chk("rnd pred_taken_o",  32'(bus.pred_taken_o), 32'(m_pt(m_pc)));
         chk("rnd pred_target_o", bus.pred_target_o,     m_ptgt(m_pc));
         chk("rnd flush_o",       32'(bus.flush_o),      32'(m_flush()));
         chk("rnd mispred_cnt_o", bus.mispred_cnt_o,     m_cnt);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
